// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared FSM encoding and video/obstacle bus field offsets
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PLAYING   = 2'd1,
        ST_INVULN    = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;

    localparam int OBS_X_HI     = 35;
    localparam int OBS_X_LO     = 24;
    localparam int OBS_Y_HI     = 23;
    localparam int OBS_Y_LO     = 12;
    localparam int OBS_RGB_HI   = 11;
    localparam int OBS_RGB_LO   = 0;

    localparam int DS_VCOUNT_HI = 27;
    localparam int DS_VCOUNT_LO = 16;
    localparam int DS_VSYNC     = 15;
    localparam int DS_VBLNK     = 14;
    localparam int DS_HCOUNT_HI = 13;
    localparam int DS_HCOUNT_LO = 2;
    localparam int DS_HSYNC     = 1;
    localparam int DS_HBLNK     = 0;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge detector against the previous-cycle input
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/player_damage_control.sv
// rtl/player_damage_control.sv - per-frame hitbox collision, lives and post-hit immunity
// DAMAGE_FLASH_EN: blink the player sprite while immune.
module player_damage_control
    import game_pkg::*;
#(
    parameter int          PLAYER_SIZE   = 16,
    parameter logic [11:0] OBSTACLE_RGB  = 12'hF00,
    parameter int          START_HP      = 3,
    parameter int          INVULN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_selected,
    input  logic [35:0] obstacle_data,
    input  logic [27:0] delayed_signals,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [2:0]  hp,
    output logic        hit,
    output logic        invulnerable,
    output logic        game_over,
    output logic        player_visible
);

    // Counter keeps at least 4 bits so the blink phase bit always exists.
    localparam int CW = ($clog2(INVULN_FRAMES + 1) < 4) ? 4 : $clog2(INVULN_FRAMES + 1);
    localparam logic [CW-1:0] INVULN_LOAD = CW'(INVULN_FRAMES);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [2:0]    HP_START    = 3'(START_HP);

`ifdef DAMAGE_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    logic [11:0] rgb;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic        hblnk;
    logic        in_x;
    logic        in_y;
    logic        pix_hit;
    logic        vs_rise;
    logic        unused_inputs;

    state_t        state;
    logic [CW-1:0] frame_cnt;
    logic          frame_hit;

    assign rgb    = obstacle_data[OBS_RGB_HI:OBS_RGB_LO];
    assign hcount = delayed_signals[DS_HCOUNT_HI:DS_HCOUNT_LO];
    assign vcount = delayed_signals[DS_VCOUNT_HI:DS_VCOUNT_LO];
    assign vsync  = delayed_signals[DS_VSYNC];
    assign vblnk  = delayed_signals[DS_VBLNK];
    assign hblnk  = delayed_signals[DS_HBLNK];

    assign unused_inputs = ^{obstacle_data[OBS_X_HI:OBS_Y_LO], delayed_signals[DS_HSYNC]};

    // 13-bit compare so a hitbox hanging off the right/bottom edge never wraps to 0.
    assign in_x = ({1'b0, hcount} >= {1'b0, xpos}) &&
                  ({1'b0, hcount} <  ({1'b0, xpos} + 13'(PLAYER_SIZE)));
    assign in_y = ({1'b0, vcount} >= {1'b0, ypos}) &&
                  ({1'b0, vcount} <  ({1'b0, ypos} + 13'(PLAYER_SIZE)));

    assign pix_hit = !hblnk && !vblnk && in_x && in_y && (rgb == OBSTACLE_RGB);

    edge_detect u_vsync_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (vsync),
        .rise (vs_rise)
    );

    function automatic logic blink(input logic [CW-1:0] c);
        return FLASH_EN ? ~c[3] : 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            hp             <= HP_START;
            hit            <= 1'b0;
            invulnerable   <= 1'b0;
            game_over      <= 1'b0;
            player_visible <= 1'b1;
            frame_cnt      <= '0;
            frame_hit      <= 1'b0;
        end else begin
            hit <= 1'b0;
            // A pixel landing on the vsync edge seeds the next frame's latch.
            frame_hit <= vs_rise ? pix_hit : (frame_hit | pix_hit);

            case (state)
                ST_IDLE: begin
                    frame_hit <= 1'b0;
                    if (play_selected) begin
                        state <= ST_PLAYING;
                        hp    <= HP_START;
                    end
                end

                ST_PLAYING: begin
                    if (!play_selected) begin
                        state <= ST_IDLE;
                    end else if (vs_rise && frame_hit) begin
                        hit       <= 1'b1;
                        hp        <= (hp == 3'd0) ? 3'd0 : hp - 3'd1;
                        frame_cnt <= INVULN_LOAD;
                        if (hp <= 3'd1) begin
                            state     <= ST_GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state          <= ST_INVULN;
                            invulnerable   <= 1'b1;
                            player_visible <= blink(INVULN_LOAD);
                        end
                    end
                end

                ST_INVULN: begin
                    if (!play_selected) begin
                        state          <= ST_IDLE;
                        invulnerable   <= 1'b0;
                        player_visible <= 1'b1;
                    end else if (vs_rise) begin
                        frame_cnt <= (frame_cnt == '0) ? '0 : frame_cnt - CNT_ONE;
                        if (frame_cnt <= CNT_ONE) begin
                            state          <= ST_PLAYING;
                            invulnerable   <= 1'b0;
                            player_visible <= 1'b1;
                        end else begin
                            player_visible <= blink(frame_cnt - CNT_ONE);
                        end
                    end
                end

                ST_GAME_OVER: begin
                    if (!play_selected) begin
                        state     <= ST_IDLE;
                        game_over <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_player_damage_control.sv
// tb/tb_player_damage_control.sv - randomized and directed bench against a lives/immunity model
module tb_player_damage_control;

    localparam int          START   = 3;
    localparam int          IMMUNE  = 60;
    localparam int          SIZE    = 16;
    localparam logic [11:0] HIT_RGB = 12'hF00;

`ifdef DAMAGE_FLASH_EN
    localparam bit FLASH = 1'b1;
`else
    localparam bit FLASH = 1'b0;
`endif

    localparam int K_NONE = 0, K_HIT = 1, K_MISS_X = 2, K_MISS_RGB = 3, K_EDGE = 4, K_RAND = 5;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        play = 1'b0;
    logic [11:0] xpos = 12'd100;
    logic [11:0] ypos = 12'd100;
    logic [11:0] hc = '0, vc = '0, rgb = '0, ox = '0, oy = '0;
    logic        vs = 1'b0, vb = 1'b0, hb = 1'b0, hs = 1'b0;

    logic [35:0] obstacle_data;
    logic [27:0] delayed_signals;
    logic [2:0]  hp;
    logic        hit, invulnerable, game_over, player_visible;

    int n_cmp = 0;
    int n_bad = 0;
    int hit_seen = 0;

    // Model: lives, remaining immune frames, running/dead flags, pending frame hit.
    int m_lives, m_immune;
    bit m_running, m_dead, m_pending, m_prev_vs, m_hit;

    assign obstacle_data   = {ox, oy, rgb};
    assign delayed_signals = {vc, vs, vb, hc, hs, hb};

    player_damage_control dut (
        .clk             (clk),
        .rst             (rst),
        .play_selected   (play),
        .obstacle_data   (obstacle_data),
        .delayed_signals (delayed_signals),
        .xpos            (xpos),
        .ypos            (ypos),
        .hp              (hp),
        .hit             (hit),
        .invulnerable    (invulnerable),
        .game_over       (game_over),
        .player_visible  (player_visible)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, want);
        end
    endtask

    function automatic bit pixel_hits();
        int x = int'(xpos);
        int y = int'(ypos);
        int h = int'(hc);
        int v = int'(vc);
        return !hb && !vb && (h >= x) && (h < x + SIZE) && (v >= y) && (v < y + SIZE) && (rgb == HIT_RGB);
    endfunction

    function automatic int exp_inv();
        return (m_running && m_immune > 0) ? 1 : 0;
    endfunction

    function automatic int exp_vis();
        if (FLASH && exp_inv() == 1)
            return ((m_immune >> 3) & 1) ? 0 : 1;
        return 1;
    endfunction

    task automatic model_reset();
        m_lives = START; m_immune = 0;
        m_running = 0; m_dead = 0; m_pending = 0; m_prev_vs = 0; m_hit = 0;
    endtask

    task automatic model_step();
        bit px;
        bit edge_now;
        px        = pixel_hits();
        edge_now  = vs && !m_prev_vs;
        m_prev_vs = vs;
        m_hit     = 0;
        if (m_dead) begin
            m_pending = 0;
            if (!play) m_dead = 0;
        end else if (!m_running) begin
            m_pending = 0;
            if (play) begin
                m_running = 1; m_lives = START; m_immune = 0;
            end
        end else if (!play) begin
            m_running = 0; m_immune = 0; m_pending = 0;
        end else begin
            if (edge_now) begin
                if (m_immune > 0) begin
                    m_immune--;
                end else if (m_pending) begin
                    m_hit = 1;
                    m_lives--;
                    if (m_lives == 0) begin
                        m_dead = 1; m_running = 0;
                    end else begin
                        m_immune = IMMUNE;
                    end
                end
            end
            m_pending = edge_now ? px : (m_pending | px);
        end
    endtask

    task automatic compare_all();
        check("hp", int'(hp), m_lives);
        check("hit", int'(hit), int'(m_hit));
        check("invulnerable", int'(invulnerable), exp_inv());
        check("game_over", int'(game_over), int'(m_dead));
        check("player_visible", int'(player_visible), exp_vis());
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else model_step();
        #1;
        compare_all();
        if (hit) hit_seen++;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic set_pixel(input int kind, input bit slot);
        ox = 12'($urandom); oy = 12'($urandom); hs = 1'($urandom);
        vs = 1'b0; vb = 1'b0; hb = 1'b0;
        hc = 12'($urandom); vc = 12'($urandom); rgb = 12'h000;
        if (slot) begin
            case (kind)
                K_HIT:      begin hc = 12'd108; vc = 12'd108; rgb = HIT_RGB; end
                K_MISS_X:   begin hc = 12'd116; vc = 12'd108; rgb = HIT_RGB; end
                K_MISS_RGB: begin hc = 12'd108; vc = 12'd108; rgb = 12'h0F0; end
                default:    ;
            endcase
        end
        if (kind == K_RAND) begin
            hc  = xpos - 12'd3 + 12'($urandom_range(0, 21));
            vc  = ypos - 12'd3 + 12'($urandom_range(0, 21));
            rgb = ($urandom_range(0, 2) == 0) ? HIT_RGB : 12'($urandom);
            vb  = ($urandom_range(0, 5) == 0);
            hb  = ($urandom_range(0, 5) == 0);
        end
    endtask

    task automatic run_frame(input int kind);
        int npix;
        npix = (kind == K_RAND) ? 3 + $urandom_range(0, 8) : 6;
        for (int i = 0; i < npix; i++) begin
            set_pixel((kind == K_EDGE) ? K_NONE : kind, i == 2);
            tick();
        end
        case (kind)
            K_EDGE:  set_pixel(K_HIT, 1'b1);
            K_RAND:  set_pixel(K_RAND, 1'b0);
            default: begin set_pixel(K_NONE, 1'b0); vb = 1'b1; hb = 1'b1; end
        endcase
        vs = 1'b1;
        tick();
        set_pixel(K_NONE, 1'b0); vs = 1'b1; vb = 1'b1; hb = 1'b1;
        tick();
        set_pixel(K_NONE, 1'b0); vb = 1'b1; hb = 1'b1;
        tick();
    endtask

    initial begin
        #3;
        apply_reset();
        check("reset_hp", int'(hp), 3);
        check("reset_visible", int'(player_visible), 1);
        check("reset_game_over", int'(game_over), 0);

        play = 1'b1;
        tick();
        check("start_hp", int'(hp), 3);
        check("start_invuln", int'(invulnerable), 0);
        check("start_visible", int'(player_visible), 1);

        hit_seen = 0;
        run_frame(K_HIT);
        check("hit_pulse_len", hit_seen, 1);
        check("hp_after_hit1", int'(hp), 2);
        check("invuln_after_hit1", int'(invulnerable), 1);

        for (int f = 0; f < IMMUNE; f++) run_frame(K_HIT);
        check("hp_through_immunity", int'(hp), 2);
        check("immunity_expired", int'(invulnerable), 0);

        run_frame(K_HIT);
        check("hp_after_hit2", int'(hp), 1);

        for (int f = 0; f < IMMUNE; f++) run_frame(K_NONE);
        check("immunity_expired2", int'(invulnerable), 0);
        run_frame(K_MISS_X);
        check("miss_outside_x", int'(hp), 1);
        run_frame(K_MISS_RGB);
        check("miss_wrong_rgb", int'(hp), 1);
        run_frame(K_EDGE);
        check("edge_pixel_deferred", int'(hp), 1);
        run_frame(K_NONE);
        check("hp_after_hit3", int'(hp), 0);
        check("game_over_set", int'(game_over), 1);

        play = 1'b0;
        tick();
        check("game_over_to_idle", int'(game_over), 0);

        play = 1'b1;
        tick();
        check("restart_hp", int'(hp), 3);
        run_frame(K_HIT);
        for (int f = 0; f < 20; f++) run_frame(K_NONE);
        play = 1'b0;
        tick();
        check("abort_invuln", int'(invulnerable), 0);
        check("abort_hp_hold", int'(hp), 2);

        play = 1'b1;
        tick();
        run_frame(K_HIT);
        for (int f = 0; f < 10; f++) run_frame(K_NONE);
        rst = 1'b0;
        model_reset();
        #1;
        check("async_rst_hp", int'(hp), 3);
        check("async_rst_invuln", int'(invulnerable), 0);
        compare_all();
        tick();
        rst = 1'b1;
        tick();

        for (int f = 0; f < 500; f++) begin
            if ($urandom_range(0, 29) == 0) play = ~play;
            case ($urandom_range(0, 2))
                0:       xpos = 12'd100;
                1:       xpos = 12'd4090;
                default: xpos = 12'($urandom);
            endcase
            ypos = ($urandom_range(0, 3) == 0) ? 12'd4090 : 12'd100;
            run_frame(K_RAND);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/player_damage_control.md
PLAYER_DAMAGE_CONTROL -- requirements
Module: player_damage_control

Interface
REQ-001 SHALL have parameters: PLAYER_SIZE, default 16, player hitbox side in pixels; OBSTACLE_RGB, default 12'hF00, colour that counts as a hit; START_HP, default 3, lives at game start; INVULN_FRAMES, default 60, post-hit immunity in frames.
REQ-002 SHALL have ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- play_selected  in  1  level; high while the game is running.
- obstacle_data  in  36  {obstacle_x[11:0], obstacle_y[11:0], rgb[11:0]} from the obstacle stage.
- delayed_signals  in  28  {vcount[11:0], vsync, vblnk, hcount[11:0], hsync, hblnk}; aligned with obstacle_data.
- xpos  in  12  player hitbox left edge.
- ypos  in  12  player hitbox top edge.
- hp  out  3  remaining lives.
- hit  out  1  one-cycle pulse when damage is applied.
- invulnerable  out  1  high during immunity.
- game_over  out  1  level; high when hp reaches 0.
- player_visible  out  1  player-sprite enable.

Function
REQ-003 A pixel hit SHALL be flagged when all of the following hold:
- hblnk=0 and vblnk=0;
- xpos <= hcount < xpos+PLAYER_SIZE;
- ypos <= vcount < ypos+PLAYER_SIZE;
- rgb == OBSTACLE_RGB.
REQ-004 Bounds SHALL use 13-bit sums, so xpos+PLAYER_SIZE > 4095 does not wrap.
REQ-005 Pixel hits SHALL OR into a frame_hit latch, registered one cycle after the pixel.
REQ-006 frame_hit SHALL be evaluated and cleared on the vsync rising edge, detected against the previous-cycle vsync.
REQ-007 The FSM SHALL have states IDLE, PLAYING, INVULN and GAME_OVER.
REQ-008 IDLE -> PLAYING when play_selected=1; on entry hp=START_HP and frame_hit is cleared.
REQ-009 PLAYING -> INVULN at a vsync edge with frame_hit=1:
- hp decrements by 1;
- hit pulses for exactly one cycle;
- the frame counter loads INVULN_FRAMES.
REQ-010 INVULN: the frame counter SHALL decrement once per vsync edge and frame_hit SHALL be ignored; at 0 the FSM returns to PLAYING.
REQ-011 When a decrement makes hp 0, the FSM SHALL go to GAME_OVER instead of INVULN; hit still pulses.
REQ-012 hp SHALL saturate at 0 and never underflow.
REQ-013 GAME_OVER SHALL hold until play_selected=0, then go to IDLE.
REQ-014 play_selected=0 in PLAYING or INVULN SHALL force IDLE on the next cycle; hp holds its value.
REQ-015 A pixel hit in the same cycle as a vsync edge SHALL count toward the next frame.
REQ-016 invulnerable SHALL be 1 only in INVULN; game_over SHALL be 1 only in GAME_OVER.
REQ-017 All outputs SHALL be registered.

Reset
REQ-018 rst=0 SHALL asynchronously set:
- state = IDLE;
- hp = START_HP;
- hit, invulnerable, game_over = 0;
- player_visible = 1;
- frame counter, frame_hit and the vsync history = 0.
REQ-019 Reset mid-frame or mid-INVULN SHALL discard the pending frame_hit and the immunity count.

Configuration
REQ-020 With DAMAGE_FLASH_EN defined, player_visible SHALL equal ~frame_counter[3] in INVULN and 1 in all other states.
REQ-021 Without DAMAGE_FLASH_EN, player_visible SHALL be constant 1 and no blink logic SHALL be synthesised.

Structure
REQ-022 A shared package game_pkg SHALL hold:
- the FSM state encoding;
- the obstacle_data field offsets (X 35:24, Y 23:12, RGB 11:0);
- the delayed_signals field offsets (vcount 27:16, vsync 15, vblnk 14, hcount 13:2, hsync 1, hblnk 0).
REQ-023 Rising-edge detection of vsync SHALL be a sub-module, edge_detect, which is reusable.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset, then play_selected=1 -> hp=3, state PLAYING, player_visible=1.
- xpos=100, ypos=100; one pixel at (108,108) with rgb=F00 -> at the next vsync edge hit pulses 1 cycle, hp=2, invulnerable=1.
- Obstacle pixels on all frames inside INVULN -> hp stays 2 for 60 frames, then PLAYING; the next hit frame gives hp=1.
- rgb=F00 at (116,108), one pixel outside the hitbox -> no hit; rgb=0F0 at (108,108) -> no hit.
- Three hit frames separated by immunity -> hp=0, game_over=1; play_selected=0 -> IDLE, game_over=0.
- rst pulsed low mid-INVULN -> immediate IDLE, hp=3; with DAMAGE_FLASH_EN, player_visible toggles every 8 frames in INVULN.
